// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry/issue records, completion status
// and the fault classification helper.
package rob_pkg;

   localparam int ROB_ENTRIES = 128;
   localparam int ROB_PTR_W   = $clog2(ROB_ENTRIES);
   localparam int UOP_W       = 32;

   typedef enum logic [2:0] {
      READY     = 3'd0,
      ISSUED    = 3'd1,
      DONE      = 3'd2,
      EXCEPTION = 3'd3,
      INTERRUPT = 3'd4,
      TRAP      = 3'd5
   } status_t;

   // Top bit flags a dependency, low bits name the producing ROB index.
   typedef logic [ROB_PTR_W:0] rob_dep_t;

   typedef struct packed {
      logic [UOP_W-1:0] uop;
      rob_dep_t [1:0]   dependent_entries;
      status_t          status;
   } rob_entry;

   typedef struct packed {
      logic [UOP_W-1:0]     uop;
      logic [ROB_PTR_W-1:0] index;
   } rob_issue;

   function automatic logic is_fault(status_t s);
      return (s == EXCEPTION) || (s == INTERRUPT) || (s == TRAP);
   endfunction

   function automatic logic is_complete(status_t s);
      return (s == DONE) || is_fault(s);
   endfunction

endpackage

// File: rtl/rob_age_select.sv
// Oldest-first picker: rotates a per-entry request vector so that the head is
// bit 0, then returns the first set bit mapped back to an absolute index.
module rob_age_select #(
   parameter int N     = 128,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     cand_in,
   input  logic [PTR_W-1:0] head_in,
   output logic             found_out,
   output logic [PTR_W-1:0] idx_out
);

   logic [N-1:0]     rotated;
   logic [PTR_W-1:0] offset;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_rot
         logic [PTR_W-1:0] src;
         assign src         = head_in + PTR_W'(gi);
         assign rotated[gi] = cand_in[src];
      end
   endgenerate

   always_comb begin
      offset = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) offset = PTR_W'(i);
      end
   end

   assign found_out = |cand_in;
   assign idx_out   = head_in + offset;

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, oldest-ready issue, out-of-order
// writeback, in-order retire with flush on faults. ROB_PERF_COUNTERS_EN adds
// retired/full-stall counters.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES,
   parameter int PTR_W       = $clog2(ROB_ENTRIES)
) (
   input  logic             clk_in,
   input  logic             rst_N_in,
   input  logic             alloc_valid_in,
   output logic             alloc_ready_out,
   input  rob_entry         alloc_entry_in,
   output logic [PTR_W-1:0] alloc_ptr_out,
   output logic             issue_valid_out,
   input  logic             issue_ready_in,
   output rob_issue         issue_out,
   input  logic             wb_valid_in,
   input  logic [PTR_W-1:0] wb_ptr_in,
   input  status_t          wb_status_in,
   output logic             commit_valid_out,
   input  logic             commit_ready_in,
   output rob_entry         commit_entry_out,
   output logic [PTR_W-1:0] commit_ptr_out,
   output logic             flush_out,
   output logic [PTR_W:0]   count_out
`ifdef ROB_PERF_COUNTERS_EN
   ,
   output logic [31:0]      retired_count_out,
   output logic [31:0]      full_stall_count_out
`endif
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(ROB_ENTRIES);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [ROB_ENTRIES-1:0] valid_q, valid_d;
   status_t          status_q [ROB_ENTRIES];
   status_t          status_d [ROB_ENTRIES];
   logic             lock_q, lock_d;
   logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
   logic             flush_q, flush_d;

   logic [UOP_W-1:0] uop_mem_q [ROB_ENTRIES];
   rob_dep_t [1:0]   dep_mem_q [ROB_ENTRIES];

   logic [ROB_ENTRIES-1:0] cand;
   logic             sel_found;
   logic [PTR_W-1:0] sel_idx, issue_idx;
   logic             head_fault;
   logic             alloc_fire, issue_fire, wb_accept, commit_fire;

   // Rename's status field is replaced by READY on entry.
   logic unused_alloc_status;
   assign unused_alloc_status = ^alloc_entry_in.status;

   generate
      for (genvar gi = 0; gi < ROB_ENTRIES; gi++) begin : g_cand
         logic [1:0] dep_ok;
         for (genvar gk = 0; gk < 2; gk++) begin : g_dep
            logic [PTR_W-1:0] prod;
            assign prod = PTR_W'(dep_mem_q[gi][gk][ROB_PTR_W-1:0]);
            assign dep_ok[gk] = !dep_mem_q[gi][gk][ROB_PTR_W] || !valid_q[prod] ||
                                (status_q[prod] == DONE);
         end
         assign cand[gi] = valid_q[gi] && (status_q[gi] == READY) && (&dep_ok);
      end
   endgenerate

   rob_age_select #(.N(ROB_ENTRIES), .PTR_W(PTR_W)) u_issue_sel (
      .cand_in   (cand),
      .head_in   (head_q),
      .found_out (sel_found),
      .idx_out   (sel_idx)
   );

   // A stalled offer is pinned so an older entry unblocked by writeback cannot displace it.
   assign issue_idx       = lock_q ? lock_idx_q : sel_idx;
   assign issue_valid_out = lock_q ? (valid_q[lock_idx_q] && (status_q[lock_idx_q] == READY))
                                   : sel_found;
   always_comb begin
      issue_out       = '0;
      issue_out.uop   = uop_mem_q[issue_idx];
      issue_out.index = ROB_PTR_W'(issue_idx);
   end

   assign head_fault       = valid_q[head_q] && is_fault(status_q[head_q]);
   assign commit_valid_out = valid_q[head_q] && is_complete(status_q[head_q]);
   always_comb begin
      commit_entry_out                   = '0;
      commit_entry_out.uop               = uop_mem_q[head_q];
      commit_entry_out.dependent_entries = dep_mem_q[head_q];
      commit_entry_out.status            = status_q[head_q];
   end

   assign alloc_ready_out = (count_q != FULL_CNT) && !head_fault;
   assign alloc_ptr_out   = tail_q;
   assign commit_ptr_out  = head_q;
   assign count_out       = count_q;
   assign flush_out       = flush_q;

   assign alloc_fire  = alloc_valid_in && alloc_ready_out;
   assign issue_fire  = issue_valid_out && issue_ready_in;
   assign commit_fire = commit_valid_out && commit_ready_in;
   assign wb_accept   = wb_valid_in && valid_q[wb_ptr_in] &&
                        (status_q[wb_ptr_in] == ISSUED) && is_complete(wb_status_in);

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      valid_d    = valid_q;
      status_d   = status_q;
      flush_d    = 1'b0;
      lock_d     = issue_valid_out && !issue_ready_in;
      lock_idx_d = issue_idx;

      if (issue_fire) status_d[issue_idx] = ISSUED;
      if (wb_accept)  status_d[wb_ptr_in] = wb_status_in;
      if (alloc_fire) begin
         valid_d[tail_q]  = 1'b1;
         status_d[tail_q] = READY;
         tail_d           = tail_q + PTR_ONE;
      end

      case ({alloc_fire, commit_fire})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      if (commit_fire) begin
         head_d = head_q + PTR_ONE;
         if (head_fault) begin
            // Everything younger than the faulting head is discarded.
            valid_d = '0;
            tail_d  = head_q + PTR_ONE;
            count_d = '0;
            flush_d = 1'b1;
            lock_d  = 1'b0;
         end else begin
            valid_d[head_q] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         flush_q    <= 1'b0;
         for (int i = 0; i < ROB_ENTRIES; i++) status_q[i] <= READY;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         flush_q    <= flush_d;
         status_q   <= status_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (alloc_fire) begin
         uop_mem_q[tail_q] <= alloc_entry_in.uop;
         dep_mem_q[tail_q] <= alloc_entry_in.dependent_entries;
      end
   end

`ifdef ROB_PERF_COUNTERS_EN
   logic [31:0] retired_q, retired_d, stall_q, stall_d;

   always_comb begin
      retired_d = retired_q + 32'(commit_fire);
      stall_d   = stall_q + 32'(alloc_valid_in && (count_q == FULL_CNT));
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         retired_q <= retired_d;
         stall_q   <= stall_d;
      end
   end

   assign retired_count_out    = retired_q;
   assign full_stall_count_out = stall_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table for issue,
// dependency and in-order commit, plus sequences for full/wrap, fault flush and reset.
module tb_reorder_buffer;
   import rob_pkg::*;

   localparam int N  = ROB_ENTRIES;
   localparam int PW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alloc_valid, alloc_ready, issue_valid, issue_ready;
   logic          wb_valid, commit_valid, commit_ready, flush;
   rob_entry      alloc_entry, commit_entry;
   rob_issue      issue;
   logic [PW-1:0] alloc_ptr, wb_ptr, commit_ptr;
   status_t       wb_status;
   logic [PW:0]   count;
`ifdef ROB_PERF_COUNTERS_EN
   logic [31:0]   retired_cnt, stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   reorder_buffer dut (
      .clk_in           (clk),
      .rst_N_in         (rst_n),
      .alloc_valid_in   (alloc_valid),
      .alloc_ready_out  (alloc_ready),
      .alloc_entry_in   (alloc_entry),
      .alloc_ptr_out    (alloc_ptr),
      .issue_valid_out  (issue_valid),
      .issue_ready_in   (issue_ready),
      .issue_out        (issue),
      .wb_valid_in      (wb_valid),
      .wb_ptr_in        (wb_ptr),
      .wb_status_in     (wb_status),
      .commit_valid_out (commit_valid),
      .commit_ready_in  (commit_ready),
      .commit_entry_out (commit_entry),
      .commit_ptr_out   (commit_ptr),
      .flush_out        (flush),
      .count_out        (count)
`ifdef ROB_PERF_COUNTERS_EN
      ,
      .retired_count_out    (retired_cnt),
      .full_stall_count_out (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [31:0] uop;
      logic [7:0]  dep0;
      logic        ir;
      logic        wv;
      logic [6:0]  wp;
      status_t     ws;
      logic        cr;
      logic        e_ardy;
      logic [6:0]  e_aptr;
      logic        e_iv;
      logic [6:0]  e_iidx;
      logic        e_cv;
      logic [6:0]  e_cptr;
      logic [7:0]  e_cnt;
      logic        e_flush;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(logic av, logic [31:0] uop, logic [7:0] dep0, logic ir,
                               logic wv, logic [6:0] wp, status_t ws, logic cr,
                               logic ardy, logic [6:0] aptr, logic iv, logic [6:0] iidx,
                               logic cv, logic [6:0] cptr, logic [7:0] cnt, logic fl);
      vec_t v;
      v.av = av; v.uop = uop; v.dep0 = dep0; v.ir = ir;
      v.wv = wv; v.wp = wp; v.ws = ws; v.cr = cr;
      v.e_ardy = ardy; v.e_aptr = aptr; v.e_iv = iv; v.e_iidx = iidx;
      v.e_cv = cv; v.e_cptr = cptr; v.e_cnt = cnt; v.e_flush = fl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [31:0] uop, input logic [7:0] dep0,
                        input logic ir, input logic wv, input logic [6:0] wp,
                        input status_t ws, input logic cr);
      alloc_valid                          = av;
      alloc_entry                          = '0;
      alloc_entry.uop                      = uop;
      alloc_entry.dependent_entries[0]     = dep0;
      alloc_entry.status                   = TRAP;
      issue_ready                          = ir;
      wb_valid                             = wv;
      wb_ptr                               = wp;
      wb_status                            = ws;
      commit_ready                         = cr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, DONE, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, DONE, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset.flush", flush, 0);
`ifdef ROB_PERF_COUNTERS_EN
      chk("reset.retired", retired_cnt, 0);
      chk("reset.stalls", stall_cnt, 0);
`endif

      //        av  uop    dep   ir wv wp ws    cr | ardy aptr iv idx cv cptr cnt fl
      tbl[0]  = mk(1, 'hA0, 'h00, 1, 0, 0, DONE,  1,  1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 'hA1, 'h00, 1, 0, 0, DONE,  1,  1, 1, 1, 0, 0, 0, 1, 0);
      tbl[2]  = mk(1, 'hA2, 'h00, 1, 0, 0, DONE,  1,  1, 2, 1, 1, 0, 0, 2, 0);
      tbl[3]  = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 3, 1, 2, 0, 0, 3, 0);
      tbl[4]  = mk(0, 'h00, 'h00, 1, 1, 2, DONE,  1,  1, 3, 0, 0, 0, 0, 3, 0);
      tbl[5]  = mk(0, 'h00, 'h00, 1, 1, 0, DONE,  1,  1, 3, 0, 0, 0, 0, 3, 0);
      tbl[6]  = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 3, 0, 0, 1, 0, 3, 0);
      tbl[7]  = mk(0, 'h00, 'h00, 1, 1, 1, DONE,  1,  1, 3, 0, 0, 0, 1, 2, 0);
      tbl[8]  = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 3, 0, 0, 1, 1, 2, 0);
      tbl[9]  = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 3, 0, 0, 1, 2, 1, 0);
      tbl[10] = mk(1, 'hB0, 'h00, 0, 0, 0, DONE,  1,  1, 3, 0, 0, 0, 3, 0, 0);
      tbl[11] = mk(1, 'hB1, 'h83, 0, 0, 0, DONE,  1,  1, 4, 1, 3, 0, 3, 1, 0);
      tbl[12] = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 5, 1, 3, 0, 3, 2, 0);
      tbl[13] = mk(0, 'h00, 'h00, 1, 1, 3, DONE,  1,  1, 5, 0, 0, 0, 3, 2, 0);
      tbl[14] = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 5, 1, 4, 1, 3, 2, 0);
      tbl[15] = mk(0, 'h00, 'h00, 1, 1, 4, READY, 1,  1, 5, 0, 0, 0, 4, 1, 0);
      tbl[16] = mk(0, 'h00, 'h00, 1, 1, 4, DONE,  1,  1, 5, 0, 0, 0, 4, 1, 0);
      tbl[17] = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 5, 0, 0, 1, 4, 1, 0);
      tbl[18] = mk(1, 'hC0, 'h80, 1, 0, 0, DONE,  1,  1, 5, 0, 0, 0, 5, 0, 0);
      tbl[19] = mk(0, 'h00, 'h00, 1, 0, 0, DONE,  1,  1, 6, 1, 5, 0, 5, 1, 0);
      tbl[20] = mk(0, 'h00, 'h00, 0, 0, 0, DONE,  1,  1, 6, 0, 0, 0, 5, 1, 0);

      for (int k = 0; k < 21; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("v%0d.alloc_ready", k), alloc_ready, tbl[k].e_ardy);
         chk($sformatf("v%0d.alloc_ptr", k), alloc_ptr, tbl[k].e_aptr);
         chk($sformatf("v%0d.issue_valid", k), issue_valid, tbl[k].e_iv);
         if (tbl[k].e_iv) chk($sformatf("v%0d.issue_idx", k), issue.index, tbl[k].e_iidx);
         chk($sformatf("v%0d.commit_valid", k), commit_valid, tbl[k].e_cv);
         chk($sformatf("v%0d.commit_ptr", k), commit_ptr, tbl[k].e_cptr);
         chk($sformatf("v%0d.count", k), count, tbl[k].e_cnt);
         chk($sformatf("v%0d.flush", k), flush, tbl[k].e_flush);
         $display("vec %0d: iv=%0d idx=%0d cv=%0d cptr=%0d cnt=%0d", k, issue_valid,
                  issue.index, commit_valid, commit_ptr, count);
         drive(tbl[k].av, tbl[k].uop, tbl[k].dep0, tbl[k].ir, tbl[k].wv, tbl[k].wp,
               tbl[k].ws, tbl[k].cr);
      end

      // Full buffer, stall, commit re-opens allocation at wrapped index 0.
      do_reset();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         drive(1, 32'h1000 + i, 0, 0, 0, 0, DONE, 0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full.alloc_ready", alloc_ready, 0);
         chk("full.count", count, N);
         chk("full.alloc_ptr", alloc_ptr, 0);
         $display("full stall %0d: count=%0d", i, count);
         drive(1, 32'hDEAD, 0, 0, 0, 0, DONE, 0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full.issue_valid", issue_valid, 1);
         chk("full.issue_idx", issue.index, i);
         $display("full issue: idx=%0d", issue.index);
         drive(0, 0, 0, 1, 0, 0, DONE, 0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 1, 7'(i), DONE, 0);
      end
      @(negedge clk);
      chk("full.commit_valid", commit_valid, 1);
      chk("full.commit_ptr", commit_ptr, 0);
      chk("full.commit_uop", commit_entry.uop, 32'h1000);
      chk("full.ready_during_commit", alloc_ready, 0);
      drive(1, 32'h2000, 0, 0, 0, 0, DONE, 1);
      @(negedge clk);
      chk("wrap.alloc_ready", alloc_ready, 1);
      chk("wrap.alloc_ptr", alloc_ptr, 0);
      chk("wrap.count", count, N - 1);
      $display("wrap: alloc_ptr=%0d count=%0d", alloc_ptr, count);
      drive(1, 32'h2000, 0, 0, 0, 0, DONE, 0);
      @(negedge clk);
      chk("wrap.refull", count, N);
      chk("wrap.commit1_uop", commit_entry.uop, 32'h1001);
      drive(0, 0, 0, 0, 0, 0, DONE, 1);
      @(negedge clk);
      chk("wrap.commit2_ptr", commit_ptr, 2);
      chk("wrap.commit2_valid", commit_valid, 1);
      drive(0, 0, 0, 0, 0, 0, DONE, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, DONE, 0);
      chk("wrap.count_after", count, N - 2);
      chk("wrap.head3_not_done", commit_valid, 0);
`ifdef ROB_PERF_COUNTERS_EN
      chk("perf.retired", retired_cnt, 3);
      chk("perf.stalls", stall_cnt, 4);
`endif

      // Asynchronous reset in the middle of operation.
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset.count", count, 0);
      chk("mid_reset.alloc_ptr", alloc_ptr, 0);
      chk("mid_reset.commit_ptr", commit_ptr, 0);
      chk("mid_reset.alloc_ready", alloc_ready, 1);
      chk("mid_reset.issue_valid", issue_valid, 0);
      chk("mid_reset.commit_valid", commit_valid, 0);
      $display("mid reset: count=%0d", count);
      @(negedge clk);
      rst_n = 1'b1;

      // Head exception with five younger entries flushes everything.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(1, 32'h3000 + i, 0, 1, 0, 0, DONE, 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, DONE, 0);
      @(negedge clk);
      chk("exc.count", count, 6);
      chk("exc.all_issued", issue_valid, 0);
      drive(0, 0, 0, 0, 1, 0, EXCEPTION, 0);
      @(negedge clk);
      chk("exc.commit_valid", commit_valid, 1);
      chk("exc.commit_status", commit_entry.status, EXCEPTION);
      chk("exc.alloc_blocked", alloc_ready, 0);
      chk("exc.no_flush_yet", flush, 0);
      drive(1, 32'hBAD, 0, 0, 0, 0, DONE, 1);
      @(negedge clk);
      chk("flush.pulse", flush, 1);
      chk("flush.count", count, 0);
      chk("flush.commit_valid", commit_valid, 0);
      chk("flush.alloc_ptr", alloc_ptr, 1);
      chk("flush.commit_ptr", commit_ptr, 1);
      chk("flush.issue_valid", issue_valid, 0);
      $display("flush: count=%0d head=%0d tail=%0d", count, commit_ptr, alloc_ptr);
      drive(0, 0, 0, 0, 1, 3, DONE, 0);
      @(negedge clk);
      chk("flush.one_cycle", flush, 0);
      chk("flush.wb_ignored_count", count, 0);
      chk("flush.wb_ignored_commit", commit_valid, 0);
      drive(0, 0, 0, 0, 1, 1, DONE, 0);
      @(negedge clk);
      chk("flush.wb1_ignored", commit_valid, 0);
      drive(1, 32'h4000, 0, 0, 0, 0, DONE, 0);
      @(negedge clk);
      chk("post.count", count, 1);
      chk("post.commit_valid", commit_valid, 0);
      chk("post.issue_valid", issue_valid, 1);
      chk("post.issue_idx", issue.index, 1);
      chk("post.issue_uop", issue.uop, 32'h4000);
      $display("post flush alloc: idx=%0d uop=%0h", issue.index, issue.uop);
      drive(0, 0, 0, 0, 0, 0, DONE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- Circular reorder buffer of `rob_pkg::rob_entry` records.
- Sits between rename (upstream, allocates in program order) and the execute/retire path (downstream).
- Issues the oldest ready, dependency-free uop as a `rob_issue`, accepts completion status from execute, and retires the head in order.
- Flushes all younger work when the head carries an EXCEPTION, INTERRUPT or TRAP.

## Interface
Parameters:
- `ROB_ENTRIES`, default `rob_pkg::ROB_ENTRIES` (128): entry count; power of two, ≥4.
- `PTR_W`, default `$clog2(ROB_ENTRIES)`: index width.

Ports (one clock; reset asynchronous, active-low):
- `clk_in` input 1: clock, rising edge.
- `rst_N_in` input 1: async active-low reset.
- `alloc_valid_in` input 1: rename offers an entry.
- `alloc_ready_out` output 1: buffer accepts the offered entry.
- `alloc_entry_in` input `$bits(rob_entry)`: entry from rename.
- `alloc_ptr_out` output `PTR_W`: index the current offer will occupy (= tail).
- `issue_valid_out` output 1: an issuable uop is presented.
- `issue_ready_in` input 1: execute accepts it.
- `issue_out` output `$bits(rob_issue)`: uop plus its ROB index.
- `wb_valid_in` input 1: completion report.
- `wb_ptr_in` input `PTR_W`: completing entry.
- `wb_status_in` input `$bits(status_t)`: completion status (DONE/EXCEPTION/INTERRUPT/TRAP).
- `commit_valid_out` output 1: head is retirable.
- `commit_ready_in` input 1: retire consumer accepts.
- `commit_entry_out` output `$bits(rob_entry)`: head entry, including its status.
- `commit_ptr_out` output `PTR_W`: head index.
- `flush_out` output 1: one-cycle pulse after a faulting commit.
- `count_out` output `PTR_W+1`: occupied entries.

## Operation
State:
- `head`, `tail` (`PTR_W`, wrap modulo `ROB_ENTRIES`).
- `count` (`PTR_W+1`).
- Per-entry valid bit.
- Entry array.

Allocation:
- `alloc_ready_out = (count < ROB_ENTRIES) && !head_faulting`, where `head_faulting` = head valid with status EXCEPTION/INTERRUPT/TRAP.
- On handshake: write entry at tail with status forced to READY, set valid, increment tail.

Dependencies:
- `dependent_entries[i]` bit `PTR_W` = dependency present; low `PTR_W` bits = producer index.
- A dependency is satisfied when the bit is 0, the producer is invalid (retired), or the producer status is DONE.

Issue:
- Candidate = oldest valid entry, in age order from head, with status READY and both dependencies satisfied.
- `issue_out = {uop, index}`.
- On handshake the entry becomes ISSUED.

Writeback:
- Applied only if the target is valid and ISSUED, and `wb_status_in` ∈ {DONE, EXCEPTION, INTERRUPT, TRAP}; otherwise ignored.

Commit:
- `commit_valid_out` = head valid and status ∈ {DONE, EXCEPTION, INTERRUPT, TRAP}.
- DONE handshake: clear head valid, increment head.
- Faulting handshake: clear all valid bits, set `head = tail = head+1`, `count = 0`, pulse `flush_out` next cycle.

Count updates by +alloc −commit. Simultaneous alloc and commit leaves `count` unchanged.

## Timing
- Reset values:
  - `alloc_ready_out=1`; `issue_valid_out=0`; `commit_valid_out=0`; `flush_out=0`.
  - `count_out=0`; `alloc_ptr_out=0`; `commit_ptr_out=0`.
  - `head=tail=0`; all valid bits 0.
  - `issue_out` and `commit_entry_out` are don't-care while their valid is 0.
- All valid/ready outputs are combinational from registered state only. There is no bypass from same-cycle inputs.
- Latencies:
  - Allocated entry can issue at earliest the next cycle.
  - Writeback DONE unblocks dependents and the head commit the next cycle.
- Issue and commit presentations hold stable until their handshake. An issue offer is not withdrawn by unrelated writebacks.
- Full (count == `ROB_ENTRIES`): `alloc_ready_out=0`. Commit in the same cycle does not re-open allocation until the next cycle.
- Empty: `issue_valid_out=0`, `commit_valid_out=0`.
- Pointers wrap from `ROB_ENTRIES-1` to 0 without a gap.
- Reset asserted mid-operation returns all state to reset values immediately; in-flight handshakes are discarded.

## Configuration
- `ROB_PERF_COUNTERS_EN` defined: adds two 32-bit outputs, both reset to 0 and wrapping on overflow:
  - `retired_count_out`: +1 per commit handshake.
  - `full_stall_count_out`: +1 per cycle with `alloc_valid_in && count == ROB_ENTRIES`.
- Undefined: these ports and counters do not exist.

## Structure
- `rob_pkg` holds `ROB_ENTRIES`, `status_t`, `rob_entry`, `rob_issue`, and a new helper function `is_fault(status_t)`.
- Submodule `rob_age_select`: rotates the candidate bit vector by `head` and returns the oldest set index plus a found flag. It is reused for issue selection.

## Test plan
- Reset, allocate entries 0..2 with no dependencies, hold `issue_ready_in=1` -> issues ptr 0, 1, 2 on consecutive cycles, starting the cycle after the first allocation.
- Entry 1 depends on 0 (dependency field = `{1,0}`); writeback 0 DONE in cycle t -> entry 1 first offered in cycle t+1.
- Fill 128 entries -> `alloc_ready_out=0`, `count_out=128`; one commit -> allocation re-opens next cycle at index 0 after the wrap.
- Writeback out of order (2 DONE, then 0 DONE) -> commits occur only in order 0, 1, 2, with 1 waiting for its own DONE.
- Head writeback EXCEPTION with 5 younger entries -> commit presents status EXCEPTION; after handshake `count_out=0`, `flush_out=1` for one cycle, writebacks to the flushed indices are ignored.
- With `ROB_PERF_COUNTERS_EN`: 3 commits and 4 full-stall cycles -> `retired_count_out=3`, `full_stall_count_out=4`.
